// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
// Also holds the index-width helper reused by the round-robin picker.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int unsigned CLK_HZ = 12_000_000;
    localparam int unsigned BAUD   = 115_200;
    // One bit period of the transmitter, used as the stop-bit guard gap.
    localparam int unsigned DIVI           = CLK_HZ / BAUD;
    localparam int          GAP_CYCLES_DEF = int'(DIVI);
    localparam int          CNT_W          = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus the level start / busy link to uart_tx.
// The arbiter uses the slave view; producers and the transmitter model use master.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit after last_i, wrapping.
// Returns the winner as one-hot and as an index, plus an any-eligible flag.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int            c;
        logic [IW-1:0] ci;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            c  = (int'(last_i) + k) % N;
            ci = IW'(c);
            if (!any_o && mask_i[ci]) begin
                any_o        = 1'b1;
                idx_o        = ci;
                onehot_o[ci] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers with round-robin arbitration,
// packet lock, a post-busy guard gap and a start timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
    parameter int START_TIMEOUT = 255,
    parameter int IW            = clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_arbiter_if.slave    bus,
    output logic [IW-1:0]       grant_id,
    output logic                active,
    output logic                err_timeout
);

    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               lock_q, lock_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [7:0]         data_q, data_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] eligible, pick_oh, ready_c;
    logic [IW-1:0]      pick_idx;
    logic               pick_any, start_c;

    // While a packet is locked only its owner may compete.
    assign eligible = lock_q ? (bus.req_valid & (NUM_REQ'(1) << owner_q)) : bus.req_valid;

    uart_tx_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .mask_i   (eligible),
        .last_i   (last_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        data_d  = data_q;
        err_d   = 1'b0;
        ready_c = '0;
        start_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = reset ? '0 : pick_oh;
                if (pick_any) begin
                    data_d  = bus.req_data[{pick_idx, 3'b000} +: 8];
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    owner_d = pick_idx;
                    lock_d  = ~bus.req_last[pick_idx];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                start_c = 1'b1;
                cnt_d   = cnt_inc;
                // Busy takes priority over a timeout landing on the same clock.
                if (bus.tx_busy) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else if (cnt_q >= TO_LIM) begin
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!bus.tx_busy) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_inc;
                if (cnt_q >= GAP_LIM) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.tx_start  = start_c;
    assign bus.tx_data   = data_q;
    assign grant_id      = grant_q;
    assign active        = (state_q != IDLE) || lock_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: producer queues, a uart_tx model and
// a queue-based round-robin reference feeding an independent output monitor.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NR  = 3;
    localparam int GAP = 104;
    localparam int TO  = 255;

    typedef struct packed { logic [7:0] d; logic l; } item_t;
    typedef struct packed { logic [7:0] id; logic [7:0] d; } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant_id;
    logic       active;
    logic       err_timeout;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) intf();

    uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .START_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (intf),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    item_t pq[NR][$];
    exp_t  expq[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    mode = 0;
    int    last_fall = 0;
    bit    have_fall = 1'b0;
    int    start_len = 0;
    int    err_cnt = 0;
    int    model_last = NR - 1;
    int    hs_cnt[NR] = '{default: 0};
    bit    bench_lock;
    int    lock_owner;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        item_t it;
        it.d = d;
        it.l = l;
        pq[i].push_back(it);
    endtask

    // Reference: walks the pending producer queues applying round-robin and lock.
    task automatic model(input bit drop_first);
        item_t mq[NR][$];
        item_t it;
        exp_t  e;
        bit    lk;
        int    own, cur, n, w, c;
        lk = 1'b0; own = 0; cur = model_last; n = 0;
        for (int i = 0; i < NR; i++) mq[i] = pq[i];
        forever begin
            w = -1;
            if (lk) w = own;
            else
                for (int k = 1; k <= NR; k++) begin
                    c = (cur + k) % NR;
                    if (w < 0 && mq[c].size() > 0) w = c;
                end
            if (w < 0) break;
            if (mq[w].size() == 0) break;
            it = mq[w].pop_front();
            e.id = 8'(w);
            e.d  = it.d;
            expq.push_back(e);
            cur = w;
            own = w;
            lk  = (drop_first && n == 0) ? 1'b0 : !it.l;
            n++;
        end
        model_last = cur;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        bit done;
        t = 0; done = 1'b0;
        while (!done && t < budget) begin
            @(negedge clk); #1;
            t++;
            done = pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 &&
                   expq.size() == 0 && !active && !intf.tx_busy;
        end
        check("idle_reached", 32'(done), 1);
        repeat (2) @(negedge clk);
    endtask

    // Producers: present queue heads, pop on handshake, watch ready rules.
    initial begin
        logic [NR-1:0] hs;
        intf.req_valid = '0;
        intf.req_data  = '0;
        intf.req_last  = '0;
        bench_lock = 1'b0;
        lock_owner = 0;
        forever begin
            @(negedge clk);
            if (reset || err_timeout) bench_lock = 1'b0;
            hs = reset ? '0 : (intf.req_valid & intf.req_ready);
            if (!reset && intf.req_ready != '0) begin
                check("ready_onehot", $countones(intf.req_ready), 1);
                check("ready_subset_valid", 32'(intf.req_ready & ~intf.req_valid), 0);
                if (bench_lock)
                    check("ready_during_lock", 32'(intf.req_ready) & ~(32'd1 << lock_owner), 0);
            end
            for (int i = 0; i < NR; i++)
                if (hs[i]) begin
                    hs_cnt[i]++;
                    if (pq[i].size() > 0) begin
                        bench_lock = !pq[i][0].l;
                        lock_owner = i;
                    end
                end
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                if (pq[i].size() > 0) begin
                    intf.req_valid[i]        = 1'b1;
                    intf.req_data[8*i +: 8]  = pq[i][0].d;
                    intf.req_last[i]         = pq[i][0].l;
                end else begin
                    intf.req_valid[i]        = 1'b0;
                    intf.req_data[8*i +: 8]  = 8'h00;
                    intf.req_last[i]         = 1'b0;
                end
            end
        end
    end

    // uart_tx model: mode 0 normal, 1 never busy, 2 busy on the last legal START clock.
    initial begin
        int scnt, bcnt, dly;
        scnt = 0; bcnt = 0; dly = 2;
        intf.tx_busy = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                intf.tx_busy = 1'b0;
                bcnt = 0; scnt = 0;
                have_fall = 1'b0;
            end else if (intf.tx_busy) begin
                bcnt--;
                if (bcnt <= 0) begin
                    intf.tx_busy = 1'b0;
                    last_fall = cyc;
                    have_fall = 1'b1;
                end
            end else if (intf.tx_start) begin
                scnt++;
                if ((mode == 0 && scnt >= dly) || (mode == 2 && scnt == TO)) begin
                    intf.tx_busy = 1'b1;
                    bcnt = $urandom_range(12, 3);
                    scnt = 0;
                    dly  = $urandom_range(4, 1);
                end
            end else begin
                scnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every tx_start rise.
    initial begin
        bit         ps, pb;
        int         run;
        logic [7:0] cap;
        exp_t       e;
        ps = 1'b0; pb = 1'b0; run = 0; cap = 8'h00;
        forever begin
            @(negedge clk);
            if (err_timeout) err_cnt++;
            if (intf.tx_start && !ps) begin
                if (expq.size() == 0) check("unexpected_start", 1, 0);
                else begin
                    e = expq.pop_front();
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("tx_data", 32'(intf.tx_data), 32'(e.d));
                end
                if (have_fall) begin
                    n_tests++;
                    if (cyc - last_fall < GAP + 2) begin
                        n_fail++;
                        $display("FAIL guard_gap: %0d clocks from busy fall to tx_start, need >= %0d",
                                 cyc - last_fall, GAP + 2);
                    end
                end
                cap = intf.tx_data;
                run = 0;
            end
            if (intf.tx_start) run++;
            if (!intf.tx_start && ps) start_len = run;
            if (pb && !intf.tx_busy && !reset) check("tx_data_stable", 32'(intf.tx_data), 32'(cap));
            ps = intf.tx_start;
            pb = intf.tx_busy;
        end
    end

    initial begin
        int t;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(intf.tx_start), 0);
        check("rst_tx_data", 32'(intf.tx_data), 0);
        check("rst_req_ready", 32'(intf.req_ready), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_active", 32'(active), 0);
        check("rst_err", 32'(err_timeout), 0);
        reset = 1'b0;

        push(0, 8'h42, 1'b1);
        model(1'b0);
        wait_idle(2000);
        check("single_handshakes", hs_cnt[0], 1);

        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) push(i, 8'($urandom), 1'b1);
        model(1'b0);
        wait_idle(6000);

        push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
        push(0, 8'hB0, 1'b1); push(2, 8'hC2, 1'b1);
        model(1'b0);
        wait_idle(6000);

        repeat (5) begin
            for (int i = 0; i < NR; i++) begin
                int npk;
                npk = $urandom_range(2, 0);
                for (int p = 0; p < npk; p++) begin
                    int nb;
                    nb = $urandom_range(3, 1);
                    for (int b = 0; b < nb; b++) push(i, 8'($urandom), b == nb - 1);
                end
            end
            model(1'b0);
            wait_idle(8000);
        end

        mode = 1;
        push(0, 8'h5A, 1'b0); push(0, 8'h5B, 1'b1); push(1, 8'h6C, 1'b1);
        model(1'b1);
        t = 0;
        while (err_cnt == 0 && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        check("timeout_err_seen", err_cnt, 1);
        check("timeout_start_len", start_len, TO);
        check("timeout_lock_cleared", 32'(active), 0);
        mode = 0;
        wait_idle(6000);
        check("timeout_err_once", err_cnt, 1);

        mode = 2;
        push(2, 8'h77, 1'b1);
        model(1'b0);
        wait_idle(2000);
        check("race_no_err", err_cnt, 1);
        check("race_start_len", start_len, TO);
        mode = 0;

        push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b1);
        model(1'b0);
        t = 0;
        while (!intf.tx_busy && t < 1000) begin
            @(negedge clk); #1;
            t++;
        end
        check("busy_before_reset", 32'(intf.tx_busy), 1);
        @(negedge clk); #1;
        check("lock_before_reset", 32'(active), 1);
        expq.delete();
        pq[1].delete();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx_start", 32'(intf.tx_start), 0);
        check("midrst_active", 32'(active), 0);
        check("midrst_grant_id", 32'(grant_id), 0);
        check("midrst_req_ready", 32'(intf.req_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        model_last = NR - 1;
        push(2, 8'h32, 1'b1); push(0, 8'h30, 1'b1);
        model(1'b0);
        wait_idle(2000);

        check("scoreboard_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
